// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - two-port round-robin burst-read arbiter and ROM address sequencer
module rom_burst_arbiter #(
  parameter int AW = 11,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [LW-1:0] req0_len,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [LW-1:0] req1_len,
  output logic          req1_ready,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_spo,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_id,
  output logic          rd_last,
  output logic          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          cur_id_q, cur_id_d;
  logic          last_id_q, last_id_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_id_q, rd_id_d;
  logic          rd_last_q, rd_last_d;
  logic          sel;

  assign rom_a    = cur_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state_q == BURST);

  // Arbitration in IDLE, then one ROM word issued per cycle until the burst count runs out.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    cur_id_d   = cur_id_q;
    last_id_d  = last_id_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_last_d  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // On a tie the requester that was not served last wins; otherwise whoever is valid.
    sel = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~sel;
          req1_ready = sel;
          state_d    = BURST;
          cur_addr_d = sel ? req1_addr : req0_addr;
          cnt_d      = sel ? req1_len : req0_len;
          cur_id_d   = sel;
          last_id_d  = sel;
        end
      end
      BURST: begin
        rd_valid_d = 1'b1;
        rd_data_d  = rom_spo;
        rd_id_d    = cur_id_q;
        rd_last_d  = (cnt_q == '0);
        if (cnt_q == '0) begin
          // Final word: leave the address on rom_a so it holds in IDLE.
          state_d = IDLE;
        end else begin
          cur_addr_d = cur_addr_q + ADDR_ONE;
          cnt_d      = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and read-data registers with synchronous reset; an aborted burst is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      cur_id_q   <= 1'b0;
      last_id_q  <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      cur_id_q   <= cur_id_d;
      last_id_q  <= last_id_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - scoreboard bench for rom_burst_arbiter with a cycle-level reference model
module tb_rom_burst_arbiter;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        id;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        v[2];
  logic [10:0] a[2];
  logic [3:0]  l[2];
  logic        rdy0, rdy1;
  logic [10:0] rom_a;
  logic [15:0] rom_spo;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_id;
  logic        rd_last;
  logic        busy;

  int   cyc;
  int   errors;
  int   checks;
  exp_t expq[$];
  int   m_free;
  int   m_last;

  rom_burst_arbiter #(.AW(11), .DW(16), .LW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_addr  (a[0]),
    .req0_len   (l[0]),
    .req0_ready (rdy0),
    .req1_valid (v[1]),
    .req1_addr  (a[1]),
    .req1_len   (l[1]),
    .req1_ready (rdy1),
    .rom_a      (rom_a),
    .rom_spo    (rom_spo),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_id      (rd_id),
    .rd_last    (rd_last),
    .busy       (busy)
  );

  assign rom_spo = 16'(rom_a) + 16'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a requester may be granted once the previous burst's len+2 cycles have elapsed;
  // ties go to whoever was not served last. Each grant schedules its words at grant+2+i.
  always @(negedge clk) begin
    int exp0, exp1, sel, base;
    exp_t e;
    exp0 = 0;
    exp1 = 0;
    if (rst) begin
      while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
      m_last = 1;
      m_free = cyc + 1;
    end else if (cyc >= m_free && (v[0] || v[1])) begin
      sel = (v[0] && v[1]) ? (1 - m_last) : (v[1] ? 1 : 0);
      if (sel == 0) exp0 = 1; else exp1 = 1;
      base = int'(a[sel]);
      for (int i = 0; i <= int'(l[sel]); i++) begin
        e.cyc  = cyc + 2 + i;
        e.data = 16'(((base + i) % 2048) + 'h1000);
        e.id   = (sel == 1);
        e.last = (i == int'(l[sel]));
        expq.push_back(e);
      end
      m_last = sel;
      m_free = cyc + int'(l[sel]) + 2;
    end
    check("req0_ready", int'(rdy0), exp0);
    check("req1_ready", int'(rdy1), exp1);
  end

  // Monitor: every presented word must match the oldest expected word, on its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (expq.size() == 0) begin
        check("rd_spurious", int'({rd_data, rd_id, rd_last}), -1);
      end else begin
        e = expq.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_word{data,id,last}", int'({rd_data, rd_id, rd_last}), int'({e.data, e.id, e.last}));
      end
    end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      check("rd_missing_at_cycle", 0, e.cyc);
    end
  end

  // Post a request and hold it until granted or until hold cycles pass (then it is withdrawn).
  task automatic req_drive(input int id, input int addr, input int len, input int hold);
    logic got;
    a[id] = addr[10:0];
    l[id] = len[3:0];
    v[id] = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      got = (id == 0) ? rdy0 : rdy1;
      @(posedge clk);
      #1;
      if (got) break;
    end
    v[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      check("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    m_free = 0;
    m_last = 1;
    rst    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0;
      a[i] = '0;
      l[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_rd_id", int'(rd_id), 0);
    check("reset_rd_last", int'(rd_last), 0);
    check("reset_rom_a", int'(rom_a), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // Both valid from the first cycle out of reset: req0 first, then req1.
    rst = 1'b0;
    fork
      req_drive(0, 'h020, 1, 200);
      req_drive(1, 'h100, 1, 200);
    join
    drain();

    // Single burst from req0.
    req_drive(0, 'h010, 3, 200);
    drain();

    // Both held for four single-word bursts: grants alternate.
    a[0] = 11'h040; l[0] = 4'h0;
    a[1] = 11'h140; l[1] = 4'h0;
    v[0] = 1'b1; v[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    v[0] = 1'b0; v[1] = 1'b0;
    drain();

    // Address wrap at the top of the ROM.
    req_drive(1, 'h7FE, 3, 200);
    drain();

    // Reset five cycles into a long burst, then a tie must go to req0.
    req_drive(0, 'h050, 15, 200);
    repeat (4) @(posedge clk);
    #1;
    pulse_rst();
    @(negedge clk);
    check("after_rst_rd_valid", int'(rd_valid), 0);
    check("after_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    fork
      req_drive(0, 'h060, 2, 200);
      req_drive(1, 'h160, 2, 200);
    join
    drain();

    // req0 posts for one cycle during a req1 burst and withdraws: never granted.
    req_drive(1, 'h200, 7, 200);
    req_drive(0, 'h300, 2, 1);
    drain();

    // Randomized traffic with withdrawals and occasional resets.
    for (int it = 0; it < 40; it++) begin
      int en0, en1;
      en0 = $urandom_range(0, 2);
      en1 = $urandom_range(0, 2);
      fork
        if (en0 != 0) req_drive(0, $urandom_range(0, 2047), $urandom_range(0, 15), (en0 == 1) ? 200 : $urandom_range(1, 6));
        if (en1 != 0) req_drive(1, $urandom_range(0, 2047), $urandom_range(0, 15), (en1 == 1) ? 200 : $urandom_range(1, 6));
      join
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
        pulse_rst();
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Two-port burst-read arbiter and address sequencer for the 2048 x 16 distributed ROM in `top`. Two requesters each post a start address and burst length. The block grants bursts round-robin and drives the ROM address one word per cycle. It returns registered read data tagged with requester id and last-word flag. The ROM itself (combinational read, `a` -> `spo`) stays outside this block.

## Interface
Parameters:
- AW, 11, ROM address width (depth 2^AW)
- DW, 16, ROM data width
- LW, 4, burst length field width; burst = len+1 words (1..2^LW)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a burst pending
- req0_addr  in  AW  requester 0 start address
- req0_len  in  LW  requester 0 words minus one
- req0_ready  out  1  requester 0 burst accepted this cycle
- req1_valid / req1_addr / req1_len / req1_ready  same as requester 0, for requester 1
- rom_a  out  AW  ROM address
- rom_spo  in  DW  ROM combinational read data
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DW  registered ROM word
- rd_id  out  1  requester owning rd_data
- rd_last  out  1  final word of burst
- busy  out  1  burst in progress (state BURST)

## Operation
- FSM states: IDLE, BURST.
- In IDLE, if any reqN_valid is high, select one requester:
  - Only one valid: grant it.
  - Both valid: grant the requester other than `last_id`. `last_id` resets to 1, so req0 wins the first tie.
- Grant behaviour:
  - reqN_ready is combinational and high only in IDLE, only for the selected requester, and only while its valid is high. It is high for exactly one cycle per burst.
  - On valid&ready: latch addr into cur_addr, len into cnt, N into cur_id and last_id; go to BURST.
- BURST, each cycle:
  - rom_a = cur_addr.
  - Capture rom_spo into rd_data with rd_valid=1 and rd_id=cur_id on the next edge.
  - rd_last=1 when cnt==0 at issue.
  - cur_addr increments modulo 2^AW (0x7FF -> 0x000 for AW=11).
  - cnt decrements.
  - After issuing cnt==0, return to IDLE.
- Requester must hold valid/addr/len stable until ready. Deasserting valid before ready withdraws the request; no grant occurs.
- No backpressure on the rd_* side; the consumer always accepts.
- rom_a is driven from the cur_addr register and holds its last value in IDLE.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rd_valid=0, rd_data=0, rd_id=0, rd_last=0, rom_a=0, busy=0, state=IDLE, last_id=1, cnt=0.
- Accept at cycle T (IDLE, valid&ready):
  - First address on rom_a at T+1.
  - First rd_valid at T+2.
  - Words stream back-to-back on rd_valid for len+1 cycles, ending at T+len+2.
- Back-to-back bursts: one IDLE cycle between bursts. Next grant at T+len+2 gives next first data at T+len+4, i.e. one-cycle bubble on rd_valid.
- len=0: single word, rd_valid and rd_last together at T+2.
- Requests during BURST are ignored (ready=0) until IDLE.
- rst mid-burst:
  - All state clears at the reset edge; rd_valid=0 from the next cycle.
  - The aborted burst is not resumed.
  - last_id=1, so req0 wins the first tie after reset.
- rst overrides any simultaneous valid: no grant in a reset cycle.

## Test plan
Bench ROM model: spo = a + 16'h1000.
- req0 addr 0x010 len 3 -> req0_ready 1 cycle; rd_data 0x1010,0x1011,0x1012,0x1013 from accept+2, rd_id=0, rd_last only on 0x1013.
- req0 and req1 both valid from first post-reset cycle (0x020 len 1, 0x100 len 1) -> req0 served first (0x1020,0x1021, id 0), then req1 (0x1100,0x1101, id 1), with one-cycle bubble between.
- Both valid held for 4 bursts, len 0 -> grants alternate 0,1,0,1; each rd_valid has rd_last=1.
- req1 addr 0x7FE len 3 -> rom_a 0x7FE,0x7FF,0x000,0x001; rd_data 0x17FE,0x17FF,0x1000,0x1001.
- req0 len 15, rst asserted 5 cycles after accept -> rd_valid 0 cycle after rst, busy 0. Then both valid -> req0 granted first.
- req0 valid dropped after 1 cycle while req1 burst active -> no req0_ready and no req0 data ever appears.
